// File: rtl/rv2t_compressed_pack_pkg.sv
// rv2t_compressed_pack_pkg: shared RV32I/RVC encodings, packer states and helpers
package rv2t_compressed_pack_pkg;
  localparam logic [6:0] CMD_OP_IMM = 7'b0010011;
  localparam logic [6:0] CMD_OP     = 7'b0110011;
  localparam logic [6:0] CMD_LOAD   = 7'b0000011;
  localparam logic [6:0] CMD_STORE  = 7'b0100011;
  localparam logic [6:0] CMD_JALR   = 7'b1100111;
  localparam logic [31:0] RV_NOP    = 32'h00000013;
  localparam logic [31:0] RV_EBREAK = 32'h00100073;
  localparam logic [1:0] C_Q0 = 2'b00;
  localparam logic [1:0] C_Q1 = 2'b01;
  localparam logic [1:0] C_Q2 = 2'b10;
  localparam logic [2:0] C_F3_ADDI = 3'b000;
  localparam logic [2:0] C_F3_LW   = 3'b010;
  localparam logic [2:0] C_F3_MISC = 3'b100;
  localparam logic [2:0] C_F3_SW   = 3'b110;
  localparam logic [15:0] RVC_NOP    = 16'h0001;
  localparam logic [15:0] RVC_EBREAK = 16'h9002;
  typedef enum logic [1:0] {ST_EMPTY, ST_HALF, ST_FLUSH} pack_state_e;
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction
  function automatic logic fits6(input logic [11:0] imm);
    return imm[11:5] == 7'h00 || imm[11:5] == 7'h7f;
  endfunction
endpackage

// File: rtl/rv2t_compressed_pack_if.sv
// rv2t_compressed_pack_if: 32-bit valid/ready stream with end-of-stream marker
interface rv2t_compressed_pack_if;
  logic        valid;
  logic        ready;
  logic        last;
  logic [31:0] data;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/rv2t_compress_encode.sv
// rv2t_compress_encode: combinational RV32I -> RVC eligibility check and re-encoding
module rv2t_compress_encode
  import rv2t_compressed_pack_pkg::*;
(
  input  logic [31:0] instr,
  output logic        can_compress,
  output logic [15:0] c_instr
);
  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [11:0] ii, si;
  logic [1:0] fn2;
  logic ca_ok, lw_ok, lwsp_ok, sw_ok, swsp_ok, jalr_ok;
  assign {f7, rs2, rs1, f3, rd, opc} = instr;
  assign ii = instr[31:20];
  assign si = {f7, rd};
  assign fn2 = f3 == 3'b000 ? 2'b00 : f3[1:0] == 2'b00 ? 2'b01 : f3[0] ? 2'b11 : 2'b10;
  assign ca_ok = opc == CMD_OP && rd == rs1 && is_creg(rd) && is_creg(rs2) &&
                 ((f7 == 7'b0100000 && f3 == 3'b000) ||
                  (f7 == 7'b0000000 && (f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111)));
  assign lw_ok   = opc == CMD_LOAD && f3 == 3'b010 && is_creg(rd) && is_creg(rs1) &&
                   ii[11:7] == 5'd0 && ii[1:0] == 2'b00;
  assign lwsp_ok = opc == CMD_LOAD && f3 == 3'b010 && rd != 5'd0 && rs1 == 5'd2 &&
                   ii[11:8] == 4'd0 && ii[1:0] == 2'b00;
  assign sw_ok   = opc == CMD_STORE && f3 == 3'b010 && is_creg(rs1) && is_creg(rs2) &&
                   si[11:7] == 5'd0 && si[1:0] == 2'b00;
  assign swsp_ok = opc == CMD_STORE && f3 == 3'b010 && rs1 == 5'd2 &&
                   si[11:8] == 4'd0 && si[1:0] == 2'b00;
  assign jalr_ok = opc == CMD_JALR && f3 == 3'b000 && ii == 12'd0 && rs1 != 5'd0 && rd[4:1] == 4'd0;
  // Priority-ordered eligibility: each RV32I pattern maps to at most one RVC form
  always_comb begin
    can_compress = 1'b1;
    c_instr = '0;
    if (instr == RV_NOP)
      c_instr = RVC_NOP;
    else if (opc == CMD_OP_IMM && f3 == 3'b000 && rd == rs1 && rd != 5'd0 && fits6(ii) && ii != 12'd0)
      c_instr = {C_F3_ADDI, ii[5], rd, ii[4:0], C_Q1};
    else if (opc == CMD_OP_IMM && f3 == 3'b000 && rd != 5'd0 && rs1 == 5'd0 && fits6(ii))
      c_instr = {C_F3_LW, ii[5], rd, ii[4:0], C_Q1};
    else if (opc == CMD_OP_IMM && f3 == 3'b001 && f7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
      c_instr = {C_F3_ADDI, 1'b0, rd, rs2, C_Q2};
    else if (opc == CMD_OP && f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0)
      c_instr = {C_F3_MISC, 1'b0, rd, rs2, C_Q2};
    else if (opc == CMD_OP && f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0 && rs1 == rd)
      c_instr = {C_F3_MISC, 1'b1, rd, rs2, C_Q2};
    else if (ca_ok)
      c_instr = {C_F3_MISC, 3'b011, rd[2:0], fn2, rs2[2:0], C_Q1};
    else if (lw_ok)
      c_instr = {C_F3_LW, ii[5:3], rs1[2:0], ii[2], ii[6], rd[2:0], C_Q0};
    else if (lwsp_ok)
      c_instr = {C_F3_LW, ii[5], rd, ii[4:2], ii[7:6], C_Q2};
    else if (sw_ok)
      c_instr = {C_F3_SW, si[5:3], rs1[2:0], si[2], si[6], rs2[2:0], C_Q0};
    else if (swsp_ok)
      c_instr = {C_F3_SW, si[5:2], si[7:6], rs2, C_Q2};
    else if (jalr_ok)
      c_instr = {C_F3_MISC, rd[0], rs1, 5'd0, C_Q2};
    else if (instr == RV_EBREAK)
      c_instr = RVC_EBREAK;
    else
      can_compress = 1'b0;
  end
endmodule

// File: rtl/rv2t_compressed_pack.sv
// rv2t_compressed_pack: compresses eligible RV32I instructions and packs parcels into 32-bit words
module rv2t_compressed_pack
  import rv2t_compressed_pack_pkg::*;
#(
  parameter int ENABLE_COMPRESS = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  rv2t_compressed_pack_if.slave  in_s,
  rv2t_compressed_pack_if.master out_s,
  output logic [CNT_WIDTH-1:0]   total_cnt,
  output logic [CNT_WIDTH-1:0]   comp_cnt
);
  pack_state_e state_q, state_d;
  logic [15:0] p_q, p_d, c_instr;
  logic [31:0] word_d, data_q;
  logic [CNT_WIDTH-1:0] total_q, comp_q;
  logic can_c, comp, in_rdy, accept, out_free, emit, last_d, valid_q, last_q;
  rv2t_compress_encode u_enc (.instr(in_s.data), .can_compress(can_c), .c_instr(c_instr));
  assign comp = ENABLE_COMPRESS != 0 && can_c;
  assign out_free = !valid_q || out_s.ready;
  assign in_rdy = out_free && state_q != ST_FLUSH;
  assign accept = in_s.valid && in_rdy;
  assign in_s.ready = in_rdy;
  assign out_s.valid = valid_q;
  assign out_s.data = data_q;
  assign out_s.last = last_q;
  assign total_cnt = total_q;
  assign comp_cnt = comp_q;
  // Next state, next pending parcel and the word to emit this cycle
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    emit = 1'b0;
    word_d = in_s.data;
    last_d = in_s.last;
    if (state_q == ST_FLUSH) begin
      if (out_free) begin
        emit = 1'b1;
        word_d = {RVC_NOP, p_q};
        last_d = 1'b1;
        state_d = ST_EMPTY;
      end
    end else if (accept) begin
      if (state_q == ST_EMPTY && comp) begin
        p_d = c_instr;
        state_d = in_s.last ? ST_FLUSH : ST_HALF;
      end else if (state_q == ST_EMPTY) begin
        emit = 1'b1;
      end else if (comp) begin
        emit = 1'b1;
        word_d = {c_instr, p_q};
        state_d = ST_EMPTY;
      end else begin
        emit = 1'b1;
        word_d = {in_s.data[15:0], p_q};
        last_d = 1'b0;
        p_d = in_s.data[31:16];
        state_d = in_s.last ? ST_FLUSH : ST_HALF;
      end
    end
  end
  // Packer state and pending half-word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
    end
  end
  // Output register: loads only when free, otherwise holds until the sink takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (emit) begin
      valid_q <= 1'b1;
      data_q <= word_d;
      last_q <= last_d;
    end else if (out_s.ready) begin
      valid_q <= 1'b0;
    end
  end
  // Saturating statistics counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_q <= '0;
      comp_q <= '0;
    end else if (accept) begin
      total_q <= total_q == '1 ? total_q : total_q + 1'b1;
      comp_q <= comp && comp_q != '1 ? comp_q + 1'b1 : comp_q;
    end
  end
endmodule

// File: tb/tb_rv2t_compressed_pack.sv
// tb_rv2t_compressed_pack: directed scenarios for the RVC compressor/packer
module tb_rv2t_compressed_pack;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] total_a, comp_a, total_b, comp_b;
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  int tests = 0;
  int errors = 0;
  rv2t_compressed_pack_if ia ();
  rv2t_compressed_pack_if oa ();
  rv2t_compressed_pack_if ib ();
  rv2t_compressed_pack_if ob ();
  rv2t_compressed_pack #(.ENABLE_COMPRESS(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_s(ia), .out_s(oa), .total_cnt(total_a), .comp_cnt(comp_a));
  rv2t_compressed_pack #(.ENABLE_COMPRESS(0), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_s(ib), .out_s(ob), .total_cnt(total_b), .comp_cnt(comp_b));
  always #5 clk = ~clk;
  // Record every word the sink accepts, {last, data}
  always @(negedge clk) begin
    if (oa.valid && oa.ready) qa.push_back({oa.last, oa.data});
    if (ob.valid && ob.ready) qb.push_back({ob.last, ob.data});
  end
  task automatic do_reset();
    reset_n = 1'b0;
    ia.valid = 1'b0; ia.data = '0; ia.last = 1'b0; oa.ready = 1'b1;
    ib.valid = 1'b0; ib.data = '0; ib.last = 1'b0; ob.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    qa.delete();
    qb.delete();
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input bit b, input logic [31:0] instr, input bit last);
    int n = 0;
    if (b) begin ib.valid = 1'b1; ib.data = instr; ib.last = last; end
    else begin ia.valid = 1'b1; ia.data = instr; ia.last = last; end
    @(negedge clk);
    while (!(b ? ib.ready : ia.ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; errors++;
      $display("FAIL send_timeout instr %h never accepted", instr);
    end
    @(posedge clk);
    #1;
    if (b) ib.valid = 1'b0; else ia.valid = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (oa.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", oa.valid); end
    tests++; if (oa.data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", oa.data); end
    tests++; if (oa.last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", oa.last); end
    tests++; if (total_a !== 16'd0 || comp_a !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", total_a, comp_a); end
    tests++; if (ia.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ia.ready); end
    idle(1);
  endtask
  task automatic test_pair_compressed();
    logic [32:0] exp[$];
    do_reset();
    send(0, 32'h00150513, 0);
    send(0, 32'h00000513, 1);
    idle(4);
    exp = {33'h1_45010505};
    tests++; if (qa.size() != exp.size()) begin errors++; $display("FAIL pair_count got %0d want %0d", qa.size(), exp.size()); end
    foreach (exp[i]) begin tests++; if (i >= qa.size() || qa[i] !== exp[i]) begin errors++; $display("FAIL pair_word%0d got %h want %h", i, i < qa.size() ? qa[i] : 33'h0, exp[i]); end end
    tests++; if (total_a !== 16'd2 || comp_a !== 16'd2) begin errors++; $display("FAIL pair_cnt got %0d/%0d want 2/2", total_a, comp_a); end
  endtask
  task automatic test_half_then_wide();
    logic [32:0] exp[$];
    do_reset();
    send(0, 32'h00150513, 0);
    send(0, 32'h007332B3, 1);
    idle(4);
    exp = {33'h0_32B30505, 33'h1_00010073};
    tests++; if (qa.size() != exp.size()) begin errors++; $display("FAIL wide_count got %0d want %0d", qa.size(), exp.size()); end
    foreach (exp[i]) begin tests++; if (i >= qa.size() || qa[i] !== exp[i]) begin errors++; $display("FAIL wide_word%0d got %h want %h", i, i < qa.size() ? qa[i] : 33'h0, exp[i]); end end
    tests++; if (total_a !== 16'd2 || comp_a !== 16'd1) begin errors++; $display("FAIL wide_cnt got %0d/%0d want 2/1", total_a, comp_a); end
  endtask
  task automatic test_flush();
    logic [32:0] exp[$];
    do_reset();
    send(0, 32'h0004A403, 1);
    @(negedge clk);
    tests++; if (ia.ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", ia.ready); end
    idle(4);
    exp = {33'h1_00014080};
    tests++; if (qa.size() != exp.size()) begin errors++; $display("FAIL flush_count got %0d want %0d", qa.size(), exp.size()); end
    foreach (exp[i]) begin tests++; if (i >= qa.size() || qa[i] !== exp[i]) begin errors++; $display("FAIL flush_word%0d got %h want %h", i, i < qa.size() ? qa[i] : 33'h0, exp[i]); end end
    tests++; if (total_a !== 16'd1 || comp_a !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d/%0d want 1/1", total_a, comp_a); end
  endtask
  task automatic test_boundary();
    logic [32:0] exp[$];
    do_reset();
    send(0, 32'h02050513, 0);
    send(0, 32'h00050513, 0);
    send(0, 32'h008000EF, 0);
    send(0, 32'h0804A403, 0);
    send(0, 32'h00000013, 0);
    send(0, 32'h00000013, 1);
    idle(4);
    exp = {33'h0_02050513, 33'h0_00050513, 33'h0_008000EF, 33'h0_0804A403, 33'h1_00010001};
    tests++; if (qa.size() != exp.size()) begin errors++; $display("FAIL bound_count got %0d want %0d", qa.size(), exp.size()); end
    foreach (exp[i]) begin tests++; if (i >= qa.size() || qa[i] !== exp[i]) begin errors++; $display("FAIL bound_word%0d got %h want %h", i, i < qa.size() ? qa[i] : 33'h0, exp[i]); end end
    tests++; if (total_a !== 16'd6 || comp_a !== 16'd2) begin errors++; $display("FAIL bound_cnt got %0d/%0d want 6/2", total_a, comp_a); end
  endtask
  task automatic test_encodings();
    logic [31:0] ins[$];
    logic [32:0] exp[$];
    do_reset();
    ins = {32'h00B00533, 32'h00B50533, 32'h40940433, 32'h00947433,
           32'h00942223, 32'h00812503, 32'h00008067, 32'h00100073,
           32'h00351513, 32'h00B12623};
    foreach (ins[i]) send(0, ins[i], i == ins.size() - 1);
    idle(4);
    exp = {33'h0_952E852E, 33'h0_8C658C05, 33'h0_4522C044, 33'h0_90028082, 33'h1_C62E050E};
    tests++; if (qa.size() != exp.size()) begin errors++; $display("FAIL enc_count got %0d want %0d", qa.size(), exp.size()); end
    foreach (exp[i]) begin tests++; if (i >= qa.size() || qa[i] !== exp[i]) begin errors++; $display("FAIL enc_word%0d got %h want %h", i, i < qa.size() ? qa[i] : 33'h0, exp[i]); end end
    tests++; if (total_a !== 16'd10 || comp_a !== 16'd10) begin errors++; $display("FAIL enc_cnt got %0d/%0d want 10/10", total_a, comp_a); end
  endtask
  task automatic test_back_pressure();
    logic [32:0] exp[$];
    do_reset();
    oa.ready = 1'b0;
    send(0, 32'h00150513, 0);
    send(0, 32'h007332B3, 0);
    ia.valid = 1'b1; ia.data = 32'h00000013; ia.last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (oa.valid !== 1'b1 || oa.data !== 32'h32B30505) begin errors++; $display("FAIL bp_hold%0d got %b/%h want 1/32b30505", c, oa.valid, oa.data); end
      tests++; if (ia.ready !== 1'b0 || total_a !== 16'd2) begin errors++; $display("FAIL bp_stall%0d got ready %b total %0d want 0/2", c, ia.ready, total_a); end
      @(posedge clk);
      #1;
    end
    oa.ready = 1'b1;
    send(0, 32'h00000013, 1);
    idle(4);
    exp = {33'h0_32B30505, 33'h1_00010073};
    tests++; if (qa.size() != exp.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", qa.size(), exp.size()); end
    foreach (exp[i]) begin tests++; if (i >= qa.size() || qa[i] !== exp[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, i < qa.size() ? qa[i] : 33'h0, exp[i]); end end
    tests++; if (total_a !== 16'd3 || comp_a !== 16'd2) begin errors++; $display("FAIL bp_cnt got %0d/%0d want 3/2", total_a, comp_a); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    oa.ready = 1'b0;
    send(0, 32'h00150513, 0);
    send(0, 32'h007332B3, 0);
    @(negedge clk);
    tests++; if (oa.valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b want 1", oa.valid); end
    reset_n = 1'b0;
    #1;
    tests++; if (oa.valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", oa.valid); end
    tests++; if (total_a !== 16'd0 || comp_a !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d/%0d want 0/0", total_a, comp_a); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    oa.ready = 1'b1;
    qa.delete();
    send(0, 32'h00000513, 0);
    send(0, 32'h00150513, 1);
    idle(4);
    tests++; if (qa.size() != 1) begin errors++; $display("FAIL mid_count got %0d want 1", qa.size()); end
    tests++; if (qa.size() < 1 || qa[0] !== 33'h1_05054501) begin errors++; $display("FAIL mid_word got %h want 105054501", qa.size() > 0 ? qa[0] : 33'h0); end
  endtask
  task automatic test_passthrough();
    logic [32:0] exp[$];
    do_reset();
    send(1, 32'h00150513, 0);
    send(1, 32'h007332B3, 1);
    idle(4);
    exp = {33'h0_00150513, 33'h1_007332B3};
    tests++; if (qb.size() != exp.size()) begin errors++; $display("FAIL pass_count got %0d want %0d", qb.size(), exp.size()); end
    foreach (exp[i]) begin tests++; if (i >= qb.size() || qb[i] !== exp[i]) begin errors++; $display("FAIL pass_word%0d got %h want %h", i, i < qb.size() ? qb[i] : 33'h0, exp[i]); end end
    tests++; if (total_b !== 16'd2 || comp_b !== 16'd0) begin errors++; $display("FAIL pass_cnt got %0d/%0d want 2/0", total_b, comp_b); end
  endtask
  initial begin
    test_reset();
    test_pair_compressed();
    test_half_then_wide();
    test_flush();
    test_boundary();
    test_encodings();
    test_back_pressure();
    test_reset_mid();
    test_passthrough();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
